// File: rtl/gen_sched.sv
// Shares one 16-bit output channel between a timer (requester 0) and a second
// generator (requester 1): slow tick, enable pulses, and capture of owner data.
module gen_sched #(
  parameter int unsigned DIV        = 10,
  parameter int unsigned SLOT_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  output logic        t_en,
  input  logic        t_valid,
  input  logic [15:0] t_out,
  output logic        g_en,
  input  logic        g_valid,
  input  logic [15:0] g_out,
  output logic        tick,
  output logic        sel,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          rr_q, rr_d;
  logic          sel_q, sel_d;
  logic [15:0]   data_q, data_d;
  logic          dv_q, dv_d;
  logic          tick_raw;
  logic          owner_valid;
  logic [15:0]   owner_data;

  // A stop in the tick cycle suppresses both the tick and its enable.
  assign tick_raw    = (state_q == RUN) && (div_q == DW'(DIV - 1));
  assign tick        = tick_raw && !stop;
  assign t_en        = tick && !sel_q;
  assign g_en        = tick && sel_q;
  assign sel         = sel_q;
  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign busy        = (state_q != IDLE);
  assign owner_valid = sel_q ? g_valid : t_valid;
  assign owner_data  = sel_q ? g_out : t_out;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    slot_d  = slot_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    dv_d    = 1'b0;

    // sel_q still names the outgoing owner during SWITCH, so capture uses it.
    if (state_q != IDLE && owner_valid) begin
      data_d = owner_data;
      dv_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          rr_d    = mode[1];
          sel_d   = (mode == 2'b01);
          div_d   = '0;
          slot_d  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          div_d   = '0;
          slot_d  = '0;
        end else if (tick_raw) begin
          div_d = '0;
          if (rr_q) begin
            if (slot_q == SW'(SLOT_TICKS - 1)) begin
              slot_d  = '0;
              state_d = SWITCH;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SWITCH: begin
        div_d = '0;
        if (stop) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          sel_d   = !sel_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      slot_q  <= '0;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

endmodule

// File: tb/tb_gen_sched.sv
// Scoreboard bench for gen_sched (DIV=4, SLOT_TICKS=3): stimulus queues the
// expected enable cycles and captured data; a negedge monitor pops and compares.
module tb_gen_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        t_en, g_en, tick, sel, data_valid, busy;
  logic        t_valid = 1'b0, g_valid = 1'b0;
  logic [15:0] t_out = '0, g_out = '0, data_out;

  int unsigned cyc = 0;
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned exp_en_cyc[$];
  bit          exp_en_sel[$];
  logic [15:0] exp_data[$];

  gen_sched #(.DIV(4), .SLOT_TICKS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .t_en(t_en), .t_valid(t_valid), .t_out(t_out),
    .g_en(g_en), .g_valid(g_valid), .g_out(g_out),
    .tick(tick), .sel(sel), .data_out(data_out),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc < n) step();
  endtask

  task automatic push_en(input int unsigned c, input bit s);
    exp_en_cyc.push_back(c);
    exp_en_sel.push_back(s);
  endtask

  // Monitor: every enable and every data_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (t_en || g_en) begin
        chk("en_exclusive", {31'd0, t_en & g_en}, 32'd0);
        chk("en_with_tick", {31'd0, tick}, 32'd1);
        if (exp_en_cyc.size() == 0) begin
          chk("en_unexpected", {31'd0, g_en}, {31'd0, ~g_en});
        end else begin
          chk("en_cycle", exp_en_cyc.pop_front(), cyc);
          chk("en_owner", {31'd0, g_en}, {31'd0, exp_en_sel.pop_front()});
        end
      end
      if (data_valid) begin
        if (exp_data.size() == 0) begin
          chk("data_unexpected", {15'd0, data_valid, data_out}, 32'd0);
        end else begin
          chk("data_value", {16'd0, data_out}, {16'd0, exp_data.pop_front()});
        end
      end
    end
  end

  initial begin
    int unsigned s;
    #1 rst = 1'b1;
    #2;
    chk("reset_enables", {29'd0, t_en, g_en, tick}, 32'd0);
    chk("reset_sel_busy", {29'd0, sel, busy, data_valid}, 32'd0);
    chk("reset_data", {16'd0, data_out}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Timer-only mode; a later mode change must not take effect.
    s = cyc; mode = 2'b00; start = 1'b1;
    push_en(s + 4, 1'b0); push_en(s + 8, 1'b0); push_en(s + 12, 1'b0);
    step(); start = 1'b0; mode = 2'b11;
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_sel", {31'd0, sel}, 32'd0);
    wait_until(s + 5);
    t_valid = 1'b1; t_out = 16'h0005; exp_data.push_back(16'h0005);
    step(); t_valid = 1'b0;
    chk("capture_timer", {16'd0, data_out}, 32'h0005);
    wait_until(s + 13);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_idle_a", {31'd0, busy}, 32'd0);

    // Round robin: three timer ticks, SWITCH, three gen1 ticks, back to timer.
    s = cyc; mode = 2'b10; start = 1'b1;
    push_en(s + 4, 1'b0); push_en(s + 8, 1'b0); push_en(s + 12, 1'b0);
    push_en(s + 17, 1'b1); push_en(s + 21, 1'b1); push_en(s + 25, 1'b1);
    push_en(s + 30, 1'b0);
    step(); start = 1'b0; mode = 2'b00;
    wait_until(s + 6);
    g_valid = 1'b1; g_out = 16'hBEEF;
    step(); g_valid = 1'b0;
    chk("nonowner_ignored", {16'd0, data_out}, 32'h0005);
    wait_until(s + 13);
    chk("switch_no_tick", {31'd0, tick}, 32'd0);
    t_valid = 1'b1; t_out = 16'h1234; g_valid = 1'b1; g_out = 16'hAAAA;
    exp_data.push_back(16'h1234);
    step(); t_valid = 1'b0; g_valid = 1'b0;
    chk("switch_capture_outgoing", {16'd0, data_out}, 32'h1234);
    chk("sel_after_switch", {31'd0, sel}, 32'd1);
    wait_until(s + 18);
    g_valid = 1'b1; g_out = 16'h7777; exp_data.push_back(16'h7777);
    step(); g_valid = 1'b0;
    wait_until(s + 27);
    chk("sel_back_to_timer", {31'd0, sel}, 32'd0);
    wait_until(s + 31);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_idle_b", {31'd0, busy}, 32'd0);

    // Simultaneous start and stop from IDLE: stop wins.
    mode = 2'b00; start = 1'b1; stop = 1'b1;
    step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {31'd0, busy}, 32'd0);
    repeat (6) step();
    chk("still_idle", {31'd0, busy}, 32'd0);

    // Stop in the cycle the divider reaches DIV-1.
    s = cyc; mode = 2'b00; start = 1'b1;
    push_en(s + 4, 1'b0);
    step(); start = 1'b0;
    wait_until(s + 8);
    stop = 1'b1; #1;
    chk("stop_cycle_no_tick", {30'd0, tick, t_en}, 32'd0);
    step(); stop = 1'b0;
    chk("stop_tick_idle", {31'd0, busy}, 32'd0);
    chk("stop_data_held", {16'd0, data_out}, 32'h7777);

    // Asynchronous reset mid-RUN with gen1 owning, during the tick cycle.
    s = cyc; mode = 2'b01; start = 1'b1;
    step(); start = 1'b0;
    chk("gen1_sel", {31'd0, sel}, 32'd1);
    wait_until(s + 4);
    #1 rst = 1'b1;
    #1;
    chk("rst_enables", {29'd0, t_en, g_en, tick}, 32'd0);
    chk("rst_sel_busy", {29'd0, sel, busy, data_valid}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    step(); rst = 1'b0;
    step();
    s = cyc; mode = 2'b01; start = 1'b1;
    push_en(s + 4, 1'b1);
    step(); start = 1'b0;
    chk("restart_sel", {31'd0, sel}, 32'd1);
    wait_until(s + 6);
    stop = 1'b1; step(); stop = 1'b0;

    repeat (3) step();
    chk("en_queue_drained", exp_en_cyc.size(), 32'd0);
    chk("data_queue_drained", exp_data.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/gen_sched.md
Name: gen_sched

Overview:
- Scheduler that shares one 16-bit output channel between two number generators: the timer (requester 0) and a second generator (requester 1, e.g. the Fibonacci source).
- Generates the slow tick, issues enable pulses to the selected generator, and captures that generator's valid output onto a single data port.
- Sits between the button/mode inputs and the display path in the top level.

Parameters:
- DIV, 10, clk cycles per tick; DIV ≥ 2.
- SLOT_TICKS, 8, ticks per slot in round-robin mode; SLOT_TICKS ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse, begin scheduling
- stop  in  1  single-cycle pulse, halt scheduling
- mode  in  2  00 = timer only, 01 = gen1 only, 10 = round robin, 11 = treated as 10
- t_en  out  1  enable pulse to timer
- t_valid  in  1  timer output valid
- t_out  in  16  timer value
- g_en  out  1  enable pulse to generator 1
- g_valid  in  1  generator 1 output valid
- g_out  in  16  generator 1 value
- tick  out  1  one-cycle pulse every DIV cycles while running
- sel  out  1  current owner (0 = timer, 1 = gen1)
- data_out  out  16  last captured value from owner
- data_valid  out  1  one-cycle pulse when data_out updates
- busy  out  1  high in RUN or SWITCH

Behaviour:
- Reset: all outputs 0; state IDLE; divider, slot counter and latched mode cleared.
- States: IDLE, RUN, SWITCH.
- IDLE:
  - On start, latch mode and go to RUN.
  - sel loads 0 for modes 00/10/11, 1 for mode 01.
  - Divider and slot counter cleared.
- RUN:
  - Divider counts 0..DIV-1 and wraps; tick = 1 in the cycle the divider equals DIV-1.
  - First tick arrives DIV cycles after entering RUN.
  - In a tick cycle, assert t_en (sel = 0) or g_en (sel = 1) in that same cycle, combinationally from tick and sel.
  - Never more than one enable high in a cycle.
- Slot counter:
  - Increments on each tick in round-robin mode only.
  - When a tick occurs with slot counter = SLOT_TICKS-1: counter clears and the next state is SWITCH.
  - The enable for that final tick is still issued.
- SWITCH:
  - Lasts exactly one cycle; no enables.
  - Toggle sel, clear divider, return to RUN.
- Mode changes after start are ignored until the next start from IDLE.
- Capture:
  - In any state except IDLE, if the owner's valid is high, data_out <= owner's value next edge and data_valid pulses that edge.
  - Valid from the non-owner is ignored.
  - Capture uses sel as it stood before a SWITCH toggle: a valid arriving during the SWITCH cycle is still captured from the outgoing owner.
- stop:
  - From RUN or SWITCH, go to IDLE next edge.
  - No enable issued in the stop cycle, even if tick would fire.
  - Divider cleared; data_out holds its value; sel holds.
- Simultaneous start and stop: stop wins; start in RUN or SWITCH is ignored.
- busy = (state != IDLE).
- Asynchronous rst mid-operation: immediate return to reset values; any enable in flight is dropped.
- Data is 16-bit pass-through; no arithmetic on data.

Test Plan:
- DIV=4, SLOT_TICKS=3; reset, then start with mode=00 -> tick and t_en high at cycles 4, 8, 12 after start; g_en never high; sel=0; busy=1.
- Same parameters; timer asserts t_valid with t_out=0x0005 one cycle after t_en -> data_out=0x0005 and data_valid pulses one cycle the edge after t_valid.
- Start with mode=10 -> t_en on ticks 1–3, one SWITCH cycle, then sel=1, g_en on ticks 4–6, then back to sel=0.
- During a timer slot, g_valid=1 with g_out=0xBEEF -> data_out unchanged, no data_valid.
- Start and stop asserted in the same cycle from IDLE -> stays IDLE, busy=0. Stop in the cycle the divider hits DIV-1 -> no enable, IDLE next cycle, data_out retained.
- Assert rst mid-RUN with sel=1 -> all outputs 0 immediately; a later start with mode=01 -> sel=1, g_en on first tick after 4 cycles.
